// File: rtl/waterfall_log_emitter.sv
// waterfall_log_emitter: trims, decimates and log-compresses FFT bins into 8-bit waterfall rows.
// Optional WFALL_TEST_PATTERN_EN adds test_mode, replacing row data with bin_idx[8:1].
module waterfall_log_emitter #(
    parameter int DATA_W    = 16,
    parameter int NBINS     = 512,
    parameter int DECIM     = 1,
    parameter int LOG_FLOOR = 16,
    parameter int LOG_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    input  logic                     fft_valid,
    input  logic                     fft_last,
`ifdef WFALL_TEST_PATTERN_EN
    input  logic                     test_mode,
`endif
    output logic [7:0]               log_data,
    output logic                     log_valid,
    output logic                     log_last
);
    localparam int BW = $clog2(NBINS);
    localparam int FW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int EW = $clog2(DATA_W + 1);
    localparam int CW = EW + 3;

    typedef enum logic [1:0] {EMIT, DROP, SKIP} state_t;

    state_t            r_state, w_state_n;
    logic [BW-1:0]     r_bin_idx, w_bin_idx_n;
    logic [FW-1:0]     r_frame_cnt, w_frame_cnt_n, w_fc_inc;
    logic              w_accept, w_last;

    logic              r_s1_v, r_s1_last, r_s2_v, r_s2_last, r_s3_v, r_s3_last;
    logic [DATA_W-1:0] r_s1_a, r_s1_b, w_a, w_b, w_mx, w_mn;
    logic [DATA_W:0]   r_s2_mag, w_mag;
    logic [EW-1:0]     w_e;
    logic [DATA_W+3:0] w_sh;
    logic [CW-1:0]     r_s3_code, w_code;
    logic [31:0]       w_diff, w_scl;
    logic [7:0]        w_log, w_out;

`ifdef WFALL_TEST_PATTERN_EN
    logic       r_tm, w_tm;
    logic [8:0] r_s1_tp, r_s2_tp, r_s3_tp;
    assign w_tm  = r_bin_idx == '0 ? test_mode : r_tm;
    assign w_out = r_s3_tp[8] ? r_s3_tp[7:0] : w_log;
`else
    assign w_out = w_log;
`endif

    always_comb begin
        w_fc_inc      = r_frame_cnt == FW'(DECIM - 1) ? '0 : r_frame_cnt + 1'b1;
        w_accept      = fft_valid && r_state == EMIT;
        w_last        = fft_last || r_bin_idx == BW'(NBINS - 1);
        w_state_n     = r_state;
        w_bin_idx_n   = r_bin_idx;
        w_frame_cnt_n = r_frame_cnt;
        if (fft_valid && fft_last) begin
            w_bin_idx_n   = '0;
            w_frame_cnt_n = w_fc_inc;
            w_state_n     = w_fc_inc == '0 ? EMIT : SKIP;
        end else if (w_accept) begin
            w_bin_idx_n = r_bin_idx + 1'b1;
            w_state_n   = r_bin_idx == BW'(NBINS - 1) ? DROP : EMIT;
        end
    end

    // alpha-max-plus-beta-min magnitude, then leading-one exponent with a 3-bit mantissa
    always_comb begin
        w_a  = fft_re[DATA_W-1] ? -fft_re : fft_re;
        w_b  = fft_im[DATA_W-1] ? -fft_im : fft_im;
        w_mx = r_s1_a >= r_s1_b ? r_s1_a : r_s1_b;
        w_mn = r_s1_a >= r_s1_b ? r_s1_b : r_s1_a;
        w_mag = (DATA_W+1)'(w_mx) + (DATA_W+1)'(w_mn >> 2) + (DATA_W+1)'(w_mn >> 3);
        w_e  = '0;
        for (int i = 0; i <= DATA_W; i++)
            if (r_s2_mag[i]) w_e = EW'(i);
        w_sh   = {r_s2_mag, 3'b000} >> w_e;
        w_code = r_s2_mag == '0 ? '0 : {w_e, w_sh[2:0]};
        w_diff = 32'(r_s3_code) - 32'(LOG_FLOOR);
        w_scl  = w_diff << LOG_SHIFT;
        w_log  = 32'(r_s3_code) <= 32'(LOG_FLOOR) ? 8'd0 : w_scl > 32'd255 ? 8'd255 : w_scl[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMIT;
            r_bin_idx   <= '0;
            r_frame_cnt <= '0;
            r_s1_v      <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s2_v      <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_mag    <= '0;
            r_s3_v      <= 1'b0;
            r_s3_last   <= 1'b0;
            r_s3_code   <= '0;
            log_data    <= '0;
            log_valid   <= 1'b0;
            log_last    <= 1'b0;
`ifdef WFALL_TEST_PATTERN_EN
            r_tm        <= 1'b0;
            r_s1_tp     <= '0;
            r_s2_tp     <= '0;
            r_s3_tp     <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_bin_idx   <= w_bin_idx_n;
            r_frame_cnt <= w_frame_cnt_n;
            r_s1_v      <= w_accept;
            r_s1_last   <= w_accept && w_last;
            r_s1_a      <= w_a;
            r_s1_b      <= w_b;
            r_s2_v      <= r_s1_v;
            r_s2_last   <= r_s1_last;
            r_s2_mag    <= w_mag;
            r_s3_v      <= r_s2_v;
            r_s3_last   <= r_s2_last;
            r_s3_code   <= w_code;
            log_valid   <= r_s3_v;
            log_last    <= r_s3_v && r_s3_last;
            if (r_s3_v) log_data <= w_out;
`ifdef WFALL_TEST_PATTERN_EN
            if (w_accept && r_bin_idx == '0) r_tm <= test_mode;
            r_s1_tp     <= {w_tm, 8'(r_bin_idx >> 1)};
            r_s2_tp     <= r_s1_tp;
            r_s3_tp     <= r_s2_tp;
`endif
        end
    end
endmodule

// File: tb/tb_waterfall_log_emitter.sv
// tb_waterfall_log_emitter: directed checks of latency, log mapping, trim, decimation and reset flush.
module tb_waterfall_log_emitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] fft_re = '0, fft_im = '0;
    logic fft_valid = 1'b0, fft_last = 1'b0, test_mode = 1'b0;
    logic [7:0] log_data, d_data;
    logic log_valid, log_last, d_valid, d_last;

    int n_chk = 0, n_err = 0;
    int n_v = 0, n_l = 0, l_at = 0, n_bad = 0, d_v = 0, d_l = 0;
    logic [7:0] cap [0:1023];
    logic [7:0] exp_d = 8'd96;
    bit chk_d = 1'b0;

    always #5 clk = ~clk;

    waterfall_log_emitter dut (
        .clk(clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im),
        .fft_valid(fft_valid), .fft_last(fft_last),
`ifdef WFALL_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .log_data(log_data), .log_valid(log_valid), .log_last(log_last)
    );

    waterfall_log_emitter #(.DECIM(2)) dut_dec (
        .clk(clk), .rst(rst), .fft_re(fft_re), .fft_im(fft_im),
        .fft_valid(fft_valid), .fft_last(fft_last),
`ifdef WFALL_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .log_data(d_data), .log_valid(d_valid), .log_last(d_last)
    );

    always @(negedge clk) begin
        if (log_valid) begin
            cap[n_v % 1024] <= log_data;
            n_v <= n_v + 1;
            if (log_last) begin
                n_l  <= n_l + 1;
                l_at <= n_v + 1;
            end
            if (chk_d && log_data !== exp_d) n_bad <= n_bad + 1;
        end
        if (d_valid) begin
            d_v <= d_v + 1;
            if (d_last) d_l <= d_l + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit end_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fft_re    = 16'sd256;
            fft_im    = 16'sd0;
            fft_valid = 1'b1;
            fft_last  = end_last && i == n - 1;
        end
        @(posedge clk);
        #1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic one_beat(input string tag, input logic signed [15:0] re,
                            input logic signed [15:0] im, input logic [7:0] exp);
        int lat;
        @(posedge clk);
        #1;
        fft_re = re; fft_im = im; fft_valid = 1'b1; fft_last = 1'b1;
        @(posedge clk);
        #1;
        fft_valid = 1'b0; fft_last = 1'b0;
        lat = 1;
        while (!log_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_data"}, log_data, exp);
        chk({tag, "_last"}, log_last, 1);
        idle(1);
        chk({tag, "_vdrop"}, log_valid, 0);
    endtask

    initial begin
        int b, bl, snap;
        idle(2);
        chk("rst_data", log_data, 0);
        chk("rst_valid", log_valid, 0);
        chk("rst_last", log_last, 0);
        rst = 1'b0;
        idle(2);

        one_beat("zero", 16'sd0, 16'sd0, 8'd0);
        one_beat("re256", 16'sd256, 16'sd0, 8'd96);
        one_beat("im_neg256", 16'sd0, -16'sd256, 8'd96);
        one_beat("min_both", -16'sd32768, -16'sd32768, 8'd214);
        one_beat("re100_im30", 16'sd100, 16'sd30, 8'd74);
        one_beat("below_floor", 16'sd3, 16'sd0, 8'd0);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk_d = 1'b1;

        b = n_v; bl = n_l;
        send(1024, 1'b1);
        idle(8);
        chk("trim_count", n_v - b, 512);
        chk("trim_nlast", n_l - bl, 1);
        chk("trim_last_pos", l_at - b, 512);

        b = n_v; bl = n_l;
        send(100, 1'b1);
        idle(8);
        chk("short_count", n_v - b, 100);
        chk("short_nlast", n_l - bl, 1);
        chk("short_last_pos", l_at - b, 100);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        b = d_v; bl = d_l;
        send(512, 1'b1);
        idle(8);
        chk("dec_frame0", d_v - b, 512);
        send(512, 1'b1);
        idle(8);
        chk("dec_frame1", d_v - b, 512);
        send(512, 1'b1);
        idle(8);
        chk("dec_frame2", d_v - b, 1024);
        chk("dec_nlast", d_l - bl, 2);

        send(200, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", log_valid, 0);
        chk("midrst_last", log_last, 0);
        chk("midrst_data", log_data, 0);
        idle(3);
        snap = n_v;
        rst = 1'b0;
        idle(8);
        chk("midrst_flush", n_v - snap, 0);
        b = n_v; bl = n_l;
        send(512, 1'b1);
        idle(8);
        chk("post_rst_count", n_v - b, 512);
        chk("post_rst_last_pos", l_at - b, 512);
        chk("data_mismatches", n_bad, 0);

`ifdef WFALL_TEST_PATTERN_EN
        chk_d = 1'b0;
        test_mode = 1'b1;
        b = n_v;
        send(512, 1'b1);
        test_mode = 1'b0;
        idle(8);
        chk("tp_count", n_v - b, 512);
        chk("tp_bin10", cap[(b + 10) % 1024], 5);
        chk("tp_bin511", cap[(b + 511) % 1024], 255);
        chk("tp_last_pos", l_at - b, 512);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
